// File: rtl/color_detector_if.sv
// Handshake/result bundle between the sensor selector (master) and the
// color detector (slave). With RAW_COUNTS_EN defined the bundle also
// carries the raw {C,B,G,R} filter counts of the last measurement.
interface color_detector_if #(
  parameter int COUNT_W = 16
);
  logic                 startDetection;
  logic [3:0]           sensorSelect;
  logic                 detectionComplete;
  logic [2:0]           detectedColor;
  logic [3:0]           resultSensor;
`ifdef RAW_COUNTS_EN
  logic [4*COUNT_W-1:0] rawCounts;

  modport master (
    output startDetection, sensorSelect,
    input  detectionComplete, detectedColor, resultSensor, rawCounts
  );
  modport slave (
    input  startDetection, sensorSelect,
    output detectionComplete, detectedColor, resultSensor, rawCounts
  );
`else
  modport master (
    output startDetection, sensorSelect,
    input  detectionComplete, detectedColor, resultSensor
  );
  modport slave (
    input  startDetection, sensorSelect,
    output detectionComplete, detectedColor, resultSensor
  );
`endif
endinterface

// File: rtl/color_detector.sv
// color_detector: on a start pulse, steps the photodiode filters
// red/green/blue/clear, counts sensorOut rising edges over a fixed gate per
// filter after a settle delay, classifies the color and pulses completion.
// Optional feature macro: RAW_COUNTS_EN (exports {C,B,G,R} counts).
module color_detector #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int GATE_CYCLES   = 10000,
  parameter int COUNT_W       = 16,
  parameter int MIN_CLEAR     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensorOut,
  output logic [1:0]       filterSelect,
  color_detector_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_CLASSIFY} state_t;

  localparam int MAXC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TW   = $clog2(MAXC) + 1;
  localparam int CW1  = COUNT_W + 1;

  localparam logic [2:0] C_NONE   = 3'd0;
  localparam logic [2:0] C_RED    = 3'd1;
  localparam logic [2:0] C_GREEN  = 3'd2;
  localparam logic [2:0] C_BLUE   = 3'd3;
  localparam logic [2:0] C_YELLOW = 3'd4;

  state_t                    r_state, w_next;
  logic                      r_sync1, r_sync2, r_prev;
  logic [TW-1:0]             r_timer;
  logic [COUNT_W-1:0]        r_edge;
  logic [3:0][COUNT_W-1:0]   r_cnt;   // index 0 R, 1 G, 2 B, 3 C
  logic [1:0]                r_fidx;
  logic [1:0]                r_fsel;
  logic [3:0]                r_sel;
  logic                      r_done;
  logic [2:0]                r_color;
  logic [3:0]                r_result;
`ifdef RAW_COUNTS_EN
  logic [4*COUNT_W-1:0]      r_raw;
`endif

  logic                      w_rise;
  logic                      w_settle_done, w_gate_done;
  logic [COUNT_W-1:0]        w_cnt_inc;
  logic [CW1-1:0]            w_r, w_g, w_b, w_c;
  logic [CW1-1:0]            w_r125, w_g125, w_b125, w_b150;
  logic [2:0]                w_color;

  // Filter index -> {S2,S3} code: red 00, green 11, blue 01, clear 10.
  function automatic logic [1:0] f_fsel(input logic [1:0] idx);
    case (idx)
      2'd0:    f_fsel = 2'b00;
      2'd1:    f_fsel = 2'b11;
      2'd2:    f_fsel = 2'b01;
      default: f_fsel = 2'b10;
    endcase
  endfunction

  assign w_rise        = r_sync2 & ~r_prev;
  assign w_settle_done = (r_state == S_SETTLE) && (r_timer == TW'(SETTLE_CYCLES - 1));
  assign w_gate_done   = (r_state == S_COUNT)  && (r_timer == TW'(GATE_CYCLES - 1));
  // Saturating increment; includes a rise landing in the last gate cycle.
  assign w_cnt_inc     = (w_rise && (r_edge != '1)) ? r_edge + 1'b1 : r_edge;

  // Synchronize the asynchronous sensor frequency and keep the previous level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= sensorOut;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; starts outside IDLE are simply not looked at.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.startDetection) w_next = S_SETTLE;
      S_SETTLE:   if (w_settle_done) w_next = S_COUNT;
      S_COUNT:    if (w_gate_done) w_next = (r_fidx == 2'd3) ? S_CLASSIFY : S_SETTLE;
      S_CLASSIFY: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Classification on counts widened by one bit so the 1.25x/1.5x sums never wrap.
  always_comb begin
    w_r    = {1'b0, r_cnt[0]};
    w_g    = {1'b0, r_cnt[1]};
    w_b    = {1'b0, r_cnt[2]};
    w_c    = {1'b0, r_cnt[3]};
    w_r125 = w_r + (w_r >> 2);
    w_g125 = w_g + (w_g >> 2);
    w_b125 = w_b + (w_b >> 2);
    w_b150 = w_b + (w_b >> 1);
    w_color = C_NONE;
    if (w_c < CW1'(MIN_CLEAR))                    w_color = C_NONE;
    else if (w_r >= w_g125 && w_r >= w_b125)      w_color = C_RED;
    else if (w_g >= w_r125 && w_g >= w_b125)      w_color = C_GREEN;
    else if (w_b >= w_r125 && w_b >= w_g125)      w_color = C_BLUE;
    else if (w_r > w_b150 && w_g > w_b150)        w_color = C_YELLOW;
  end

  // Measurement datapath: timers, edge counting, filter stepping, result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer  <= '0;
      r_edge   <= '0;
      r_cnt    <= '0;
      r_fidx   <= 2'd0;
      r_fsel   <= 2'b00;
      r_sel    <= 4'd0;
      r_done   <= 1'b0;
      r_color  <= C_NONE;
      r_result <= 4'd0;
`ifdef RAW_COUNTS_EN
      r_raw    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.startDetection) begin
            r_sel   <= bus.sensorSelect;
            r_fidx  <= 2'd0;
            r_fsel  <= 2'b00;
            r_timer <= '0;
          end
        end
        S_SETTLE: begin
          if (w_settle_done) begin
            r_timer <= '0;
            r_edge  <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_COUNT: begin
          if (w_gate_done) begin
            r_cnt[r_fidx] <= w_cnt_inc;
            r_timer       <= '0;
            if (r_fidx != 2'd3) begin
              r_fidx <= r_fidx + 2'd1;
              r_fsel <= f_fsel(r_fidx + 2'd1);
            end
          end else begin
            r_timer <= r_timer + 1'b1;
            r_edge  <= w_cnt_inc;
          end
        end
        S_CLASSIFY: begin
          r_color  <= w_color;
          r_result <= r_sel;
          r_done   <= 1'b1;
`ifdef RAW_COUNTS_EN
          r_raw    <= {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif
        end
        default: ;
      endcase
    end
  end

  assign filterSelect          = r_fsel;
  assign bus.detectionComplete = r_done;
  assign bus.detectedColor     = r_color;
  assign bus.resultSensor      = r_result;
`ifdef RAW_COUNTS_EN
  assign bus.rawCounts         = r_raw;
`endif

endmodule

// File: tb/tb_color_detector.sv
// Directed bench for color_detector with SETTLE=4, GATE=32, MIN_CLEAR=4.
// sensorOut is a square wave whose period follows the selected filter.
module tb_color_detector;
  localparam int LAT = 4 * (4 + 32) + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensorOut = 1'b0;
  logic [1:0] filterSelect;

  color_detector_if #(.COUNT_W(16)) bus ();

  color_detector #(
    .SETTLE_CYCLES(4), .GATE_CYCLES(32), .COUNT_W(16), .MIN_CLEAR(4)
  ) dut (
    .clk(clk), .reset(reset), .sensorOut(sensorOut),
    .filterSelect(filterSelect), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ph = 0;
  int per_r = 0, per_g = 0, per_b = 0, per_c = 0;
  int s0 = 0;
  int lat;
  logic [7:0] seq;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Square-wave generator: period chosen by the filter currently selected.
  initial begin
    int p;
    forever begin
      @(negedge clk);
      ph++;
      case (filterSelect)
        2'b00:   p = per_r;
        2'b11:   p = per_g;
        2'b01:   p = per_b;
        default: p = per_c;
      endcase
      sensorOut = (p == 0) ? 1'b0 : ((ph % p) < (p / 2));
    end
  end

  task automatic set_per(input int r, input int g, input int b, input int c);
    per_r = r; per_g = g; per_b = b; per_c = c;
  endtask

  // One-cycle start pulse; s0 is the cycle number of the sampling edge.
  task automatic start_det(input logic [3:0] sel);
    @(negedge clk);
    bus.startDetection = 1'b1;
    bus.sensorSelect   = sel;
    @(negedge clk);
    bus.startDetection = 1'b0;
    s0 = cyc;
  endtask

  // Wait (bounded) for the completion pulse, tracking the filterSelect sequence.
  task automatic wait_done(output int l, output logic [7:0] sq);
    logic [1:0] last;
    bit seen;
    seen = 0;
    last = filterSelect;
    sq   = {6'd0, filterSelect};
    l    = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (bus.detectionComplete) begin
        seen = 1;
        l = cyc - s0;
      end else begin
        @(negedge clk);
        if (filterSelect != last) begin
          sq = {sq[5:0], filterSelect};
          last = filterSelect;
        end
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic near(input logic [15:0] v, input int e);
    return (int'(v) >= e - 1) && (int'(v) <= e + 1);
  endfunction

  initial begin
    int pulses;
    bus.startDetection = 1'b0;
    bus.sensorSelect   = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_fsel",  32'(filterSelect), 32'd0);
    chk("rst_done",  32'(bus.detectionComplete), 32'd0);
    chk("rst_color", 32'(bus.detectedColor), 32'd0);
    chk("rst_rsens", 32'(bus.resultSensor), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Red, sensor 5
    set_per(4, 16, 16, 2);
    start_det(4'd5);
    wait_done(lat, seq);
    chk("red_lat",   32'(lat), 32'(LAT));
    chk("red_color", 32'(bus.detectedColor), 32'd1);
    chk("red_rsens", 32'(bus.resultSensor), 32'd5);
    chk("red_seq",   32'(seq), 32'h36);
    @(negedge clk);
    chk("red_width", 32'(bus.detectionComplete), 32'd0);

    // Dark: still completes, NONE
    set_per(0, 0, 0, 0);
    start_det(4'd2);
    wait_done(lat, seq);
    chk("dark_lat",   32'(lat), 32'(LAT));
    chk("dark_color", 32'(bus.detectedColor), 32'd0);
    chk("dark_rsens", 32'(bus.resultSensor), 32'd2);

    // Yellow
    set_per(4, 4, 16, 2);
    start_det(4'd3);
    wait_done(lat, seq);
    chk("yel_color", 32'(bus.detectedColor), 32'd4);

    // Green
    set_per(16, 4, 16, 2);
    start_det(4'd4);
    wait_done(lat, seq);
    chk("grn_color", 32'(bus.detectedColor), 32'd2);

    // Busy: a second start 20 cycles in is ignored
    set_per(4, 16, 16, 2);
    start_det(4'd7);
    repeat (19) @(negedge clk);
    bus.startDetection = 1'b1;
    bus.sensorSelect   = 4'd9;
    @(negedge clk);
    bus.startDetection = 1'b0;
    wait_done(lat, seq);
    chk("busy_lat",   32'(lat), 32'(LAT));
    chk("busy_rsens", 32'(bus.resultSensor), 32'd7);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.detectionComplete) pulses++;
    end
    chk("busy_pulses", 32'(pulses), 32'd0);

    // Reset while counting the blue filter
    set_per(16, 16, 4, 2);
    start_det(4'd6);
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (filterSelect == 2'b01) got = 1;
      end
      chk("reach_blue", 32'(got), 32'd1);
    end
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_fsel",  32'(filterSelect), 32'd0);
    chk("mrst_color", 32'(bus.detectedColor), 32'd0);
    chk("mrst_rsens", 32'(bus.resultSensor), 32'd0);
    chk("mrst_done",  32'(bus.detectionComplete), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.detectionComplete) pulses++;
    end
    chk("mrst_nopulse", 32'(pulses), 32'd0);
    start_det(4'd11);
    wait_done(lat, seq);
    chk("post_color", 32'(bus.detectedColor), 32'd3);
    chk("post_rsens", 32'(bus.resultSensor), 32'd11);

    // Back-to-back: start while detectionComplete is high
    set_per(4, 16, 16, 2);
    bus.startDetection = 1'b1;
    bus.sensorSelect   = 4'd12;
    @(negedge clk);
    bus.startDetection = 1'b0;
    s0 = cyc;
    wait_done(lat, seq);
    chk("b2b_lat",   32'(lat), 32'(LAT));
    chk("b2b_seq",   32'(seq), 32'h36);
    chk("b2b_color", 32'(bus.detectedColor), 32'd1);
    chk("b2b_rsens", 32'(bus.resultSensor), 32'd12);
`ifdef RAW_COUNTS_EN
    chk("raw_r", 32'(near(bus.rawCounts[15:0],  8)), 32'd1);
    chk("raw_g", 32'(near(bus.rawCounts[31:16], 2)), 32'd1);
    chk("raw_b", 32'(near(bus.rawCounts[47:32], 2)), 32'd1);
    chk("raw_c", 32'(near(bus.rawCounts[63:48], 16)), 32'd1);
`endif
    @(negedge clk);
    chk("b2b_width", 32'(bus.detectionComplete), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
